// File: rtl/eth_rx_hdr_parser.sv
// Ethernet RX header parser: strips the 14-byte header into sideband registers
// and re-aligns the payload so payload byte 0 lands in m_axis_data[7:0].
module eth_rx_hdr_parser #(
    parameter int SIM_DELAY = 1,
    parameter int CNT_W     = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [31:0]      s_axis_data,
    input  logic [3:0]       s_axis_keep,
    input  logic             s_axis_last,
    input  logic             s_axis_valid,
    output logic             hdr_valid,
    output logic [47:0]      hdr_dst_mac,
    output logic [47:0]      hdr_src_mac,
    output logic [15:0]      hdr_eth_type,
    output logic [31:0]      m_axis_data,
    output logic [3:0]       m_axis_keep,
    output logic             m_axis_last,
    output logic             m_axis_valid,
    output logic             runt_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] runt_cnt
);

    typedef enum logic [2:0] {W0, W1, W2, W3, PAY} state_t;

    state_t      state, state_nxt;
    logic [47:0] dst_stg, src_stg;
    logic [15:0] hold;
    logic        flush;
    logic [3:0]  flush_keep;
    logic [3:0]  keep_eff;

    // Expand byte enables to a bit mask so unused output bytes read as zero.
    function automatic logic [31:0] kmask(input logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    assign keep_eff = s_axis_last ? s_axis_keep : 4'hf;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= W0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (s_axis_valid) begin
            if (s_axis_last) begin
                state_nxt = W0;
            end else begin
                case (state)
                    W0:      state_nxt = W1;
                    W1:      state_nxt = W2;
                    W2:      state_nxt = W3;
                    default: state_nxt = PAY;
                endcase
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dst_stg      <= '0;
            src_stg      <= '0;
            hold         <= '0;
            flush        <= 1'b0;
            flush_keep   <= '0;
            hdr_valid    <= 1'b0;
            hdr_dst_mac  <= '0;
            hdr_src_mac  <= '0;
            hdr_eth_type <= '0;
            m_axis_data  <= '0;
            m_axis_keep  <= '0;
            m_axis_last  <= 1'b0;
            m_axis_valid <= 1'b0;
            runt_err     <= 1'b0;
            frame_cnt    <= '0;
            runt_cnt     <= '0;
        end else begin
            hdr_valid    <= 1'b0;
            runt_err     <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_keep  <= '0;
            m_axis_last  <= 1'b0;
            flush        <= 1'b0;

            // Flush beat: tail bytes of a PAY last beat that did not fit.
            if (flush) begin
                m_axis_valid <= 1'b1;
                m_axis_data  <= {16'h0, hold} & kmask(flush_keep);
                m_axis_keep  <= flush_keep;
                m_axis_last  <= 1'b1;
            end

            if (s_axis_valid) begin
                case (state)
                    W0: begin
                        dst_stg[47:16] <= {s_axis_data[7:0], s_axis_data[15:8],
                                           s_axis_data[23:16], s_axis_data[31:24]};
                        if (s_axis_last) begin
                            runt_err <= 1'b1;
                            runt_cnt <= runt_cnt + 1'b1;
                        end
                    end
                    W1: begin
                        dst_stg[15:0]  <= {s_axis_data[7:0], s_axis_data[15:8]};
                        src_stg[47:32] <= {s_axis_data[23:16], s_axis_data[31:24]};
                        if (s_axis_last) begin
                            runt_err <= 1'b1;
                            runt_cnt <= runt_cnt + 1'b1;
                        end
                    end
                    W2: begin
                        src_stg[31:0] <= {s_axis_data[7:0], s_axis_data[15:8],
                                          s_axis_data[23:16], s_axis_data[31:24]};
                        if (s_axis_last) begin
                            runt_err <= 1'b1;
                            runt_cnt <= runt_cnt + 1'b1;
                        end
                    end
                    W3: begin
                        if (s_axis_last && !keep_eff[1]) begin
                            runt_err <= 1'b1;
                            runt_cnt <= runt_cnt + 1'b1;
                        end else begin
                            hdr_valid    <= 1'b1;
                            hdr_dst_mac  <= dst_stg;
                            hdr_src_mac  <= src_stg;
                            hdr_eth_type <= {s_axis_data[7:0], s_axis_data[15:8]};
                            frame_cnt    <= frame_cnt + 1'b1;
                            hold         <= s_axis_data[31:16];
                            // 15/16-byte frames: the whole payload sits in this beat.
                            if (s_axis_last && keep_eff[2]) begin
                                m_axis_valid <= 1'b1;
                                m_axis_data  <= {16'h0, s_axis_data[31:16]} &
                                                kmask({2'b00, keep_eff[3], keep_eff[2]});
                                m_axis_keep  <= {2'b00, keep_eff[3], keep_eff[2]};
                                m_axis_last  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        hold         <= s_axis_data[31:16];
                        m_axis_valid <= 1'b1;
                        if (keep_eff[2]) begin
                            m_axis_data <= {s_axis_data[15:0], hold};
                            m_axis_keep <= 4'hf;
                            m_axis_last <= 1'b0;
                            if (s_axis_last) begin
                                flush      <= 1'b1;
                                flush_keep <= {2'b00, keep_eff[3], 1'b1};
                            end
                        end else begin
                            m_axis_data <= {s_axis_data[15:0], hold} &
                                           kmask({keep_eff[1:0], 2'b11});
                            m_axis_keep <= {keep_eff[1:0], 2'b11};
                            m_axis_last <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
